// File: rtl/l2_req_arb.sv
// Round-robin merge of per-stream requests onto one request port with credit-based flow control.
// Optional stall counter output is built when L2_REQ_ARB_STATS_EN is defined.
module l2_req_arb #(
    parameter int nstreams = 4,
    parameter int ncredits = 16,
    parameter int idw      = $clog2(nstreams),
    parameter int cw       = $clog2(ncredits + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [nstreams-1:0] i_req_v,
    output logic [nstreams-1:0] i_req_r,
    output logic                o_req_v,
    input  logic                o_req_r,
    output logic [idw-1:0]      o_req_id,
    input  logic                i_rsp_v,
    output logic                i_rsp_r,
    input  logic [idw-1:0]      i_rsp_id,
    output logic [nstreams-1:0] o_rsp_v,
    input  logic [nstreams-1:0] o_rsp_r,
    output logic [cw-1:0]       o_credits
`ifdef L2_REQ_ARB_STATS_EN
    ,
    output logic [31:0]         o_stall_cnt
`endif
);

    localparam int PW = (nstreams > 1) ? $clog2(nstreams) : 1;

    logic                r_slot_v;
    logic [idw-1:0]      r_slot_id;
    logic [PW-1:0]       r_rr_ptr;
    logic [cw-1:0]       r_credits;

    logic                w_load;
    logic                w_found;
    logic                w_grant;
    logic [PW-1:0]       w_gnt_id;
    logic                w_rsp_hs;
    logic                w_rsp_id_ok;
    logic                w_rsp_r_sel;
    logic [nstreams-1:0] w_id_hit;

    assign w_load  = !r_slot_v || o_req_r;
    // Reset gates the grant so i_req_r stays zero while reset is held.
    assign w_grant = w_load && (r_credits != '0) && w_found && !reset;

    always_comb begin : rr_search
        int idx;
        w_found  = 1'b0;
        w_gnt_id = '0;
        idx      = 0;
        for (int k = 0; k < nstreams; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= nstreams) begin
                idx = idx - nstreams;
            end
            if (!w_found && i_req_v[idx]) begin
                w_found  = 1'b1;
                w_gnt_id = PW'(idx);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < nstreams; gi++) begin : g_stream
            assign i_req_r[gi]  = w_grant && (w_gnt_id == PW'(gi));
            assign w_id_hit[gi] = (i_rsp_id == idw'(gi));
            assign o_rsp_v[gi]  = i_rsp_v && w_id_hit[gi];
        end
    endgenerate

    // Ids beyond the stream range have no consumer; accept them so the credit still returns.
    assign w_rsp_id_ok = |w_id_hit;
    assign w_rsp_r_sel = |(w_id_hit & o_rsp_r);
    assign i_rsp_r     = w_rsp_id_ok ? w_rsp_r_sel : 1'b1;
    assign w_rsp_hs    = i_rsp_v && i_rsp_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot_v  <= 1'b0;
            r_slot_id <= '0;
            r_rr_ptr  <= '0;
            r_credits <= cw'(ncredits);
        end else begin
            if (w_load) begin
                r_slot_v <= w_grant;
                if (w_grant) begin
                    r_slot_id <= idw'(w_gnt_id);
                end
            end
            if (w_grant) begin
                r_rr_ptr <= (w_gnt_id == PW'(nstreams - 1)) ? '0 : w_gnt_id + 1'b1;
            end
            if (w_grant && !w_rsp_hs) begin
                r_credits <= r_credits - 1'b1;
            end else if (!w_grant && w_rsp_hs && (r_credits != cw'(ncredits))) begin
                r_credits <= r_credits + 1'b1;
            end
        end
    end

    assign o_req_v   = r_slot_v;
    assign o_req_id  = r_slot_id;
    assign o_credits = r_credits;

`ifdef L2_REQ_ARB_STATS_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if ((|i_req_v) && (r_credits == '0) && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_l2_req_arb.sv
// Directed and randomized checks of l2_req_arb against a transaction-level reference model.
module tb_l2_req_arb;
    localparam int N   = 4;
    localparam int NC  = 16;
    localparam int IDW = 3;
    localparam int CW  = $clog2(NC + 1);

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   i_req_v = '0;
    logic [N-1:0]   i_req_r;
    logic           o_req_v;
    logic           o_req_r = 1'b0;
    logic [IDW-1:0] o_req_id;
    logic           i_rsp_v = 1'b0;
    logic           i_rsp_r;
    logic [IDW-1:0] i_rsp_id = '0;
    logic [N-1:0]   o_rsp_v;
    logic [N-1:0]   o_rsp_r = '0;
    logic [CW-1:0]  o_credits;
`ifdef L2_REQ_ARB_STATS_EN
    logic [31:0]    o_stall_cnt;
`endif

    l2_req_arb #(.nstreams(N), .ncredits(NC), .idw(IDW)) dut (
        .clk(clk), .reset(reset),
        .i_req_v(i_req_v), .i_req_r(i_req_r),
        .o_req_v(o_req_v), .o_req_r(o_req_r), .o_req_id(o_req_id),
        .i_rsp_v(i_rsp_v), .i_rsp_r(i_rsp_r), .i_rsp_id(i_rsp_id),
        .o_rsp_v(o_rsp_v), .o_rsp_r(o_rsp_r),
        .o_credits(o_credits)
`ifdef L2_REQ_ARB_STATS_EN
        , .o_stall_cnt(o_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: slot contents, pointer and credits as plain integers.
    bit     m_v;
    int     m_id, m_ptr, m_cred;
    longint m_stall;
    bit     m_load, m_g, m_hs;
    int     m_gid;
    int     e_req_r, e_rsp_v, e_rsp_r;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_v = 0; m_id = 0; m_ptr = 0; m_cred = NC; m_stall = 0;
    endtask

    task automatic predict();
        int rid;
        m_load = !m_v || o_req_r;
        m_g = 0; m_gid = 0;
        if (m_load && m_cred > 0 && !reset) begin
            for (int k = 0; k < N; k++) begin
                if (!m_g && i_req_v[(m_ptr + k) % N]) begin
                    m_g = 1; m_gid = (m_ptr + k) % N;
                end
            end
        end
        e_req_r = m_g ? (1 << m_gid) : 0;
        rid = int'(i_rsp_id);
        e_rsp_v = (i_rsp_v && rid < N) ? (1 << rid) : 0;
        e_rsp_r = (rid < N) ? int'(o_rsp_r[rid]) : 1;
        m_hs = i_rsp_v && (e_rsp_r != 0);
    endtask

    task automatic check_all(input string tag);
        predict();
        chk({tag, ".o_req_v"}, 32'(o_req_v), 32'(m_v));
        chk({tag, ".o_req_id"}, 32'(o_req_id), 32'(m_id));
        chk({tag, ".o_credits"}, 32'(o_credits), 32'(m_cred));
        chk({tag, ".i_req_r"}, 32'(i_req_r), 32'(e_req_r));
        chk({tag, ".o_rsp_v"}, 32'(o_rsp_v), 32'(e_rsp_v));
        chk({tag, ".i_rsp_r"}, 32'(i_rsp_r), 32'(e_rsp_r));
`ifdef L2_REQ_ARB_STATS_EN
        chk({tag, ".o_stall_cnt"}, o_stall_cnt, 32'(m_stall));
`endif
    endtask

    task automatic tick();
        predict();
        if ((|i_req_v) && m_cred == 0 && m_stall < 64'hFFFF_FFFF) m_stall++;
        if (m_load) begin
            m_v = m_g;
            if (m_g) m_id = m_gid;
        end
        if (m_g) m_ptr = (m_gid + 1) % N;
        if (m_g && !m_hs) m_cred--;
        else if (!m_g && m_hs && m_cred < NC) m_cred++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        model_reset();
        reset = 1'b0;
        #1;
    endtask

    task automatic idle_inputs();
        i_req_v = '0; o_req_r = 1'b0; i_rsp_v = 1'b0; i_rsp_id = '0; o_rsp_r = '0;
    endtask

    initial begin
        int grants;
        model_reset();

        // Reset state with requests present
        i_req_v = 4'b1111;
        @(posedge clk); #2;
        chk("rst.i_req_r", 32'(i_req_r), 0);
        chk("rst.o_req_v", 32'(o_req_v), 0);
        chk("rst.o_req_id", 32'(o_req_id), 0);
        chk("rst.o_credits", 32'(o_credits), NC);
        idle_inputs();
        do_reset();

        // All streams requesting, responses looped back one cycle later
        i_req_v = 4'b1111; o_req_r = 1'b1; o_rsp_r = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            i_rsp_v = m_v; i_rsp_id = IDW'(m_id);
            #1;
            check_all("rr_loop");
            tick();
            chk("rr_loop.seq", 32'(o_req_id), 32'(c % 4));
            $display("rr_loop cycle %0d o_req_v=%0b o_req_id=%0d credits=%0d", c, o_req_v, o_req_id, o_credits);
        end
        idle_inputs();
        do_reset();

        // Credit exhaustion with no responses, then one response
        i_req_v = 4'b0001; o_req_r = 1'b1;
        grants = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            check_all("exhaust");
            if (i_req_r != '0) grants++;
            tick();
        end
        $display("exhaust grants=%0d credits=%0d", grants, o_credits);
        chk("exhaust.grants", 32'(grants), NC);
        chk("exhaust.credits", 32'(o_credits), 0);
        chk("exhaust.i_req_r", 32'(i_req_r), 0);
        i_rsp_v = 1'b1; i_rsp_id = '0; o_rsp_r = 4'b0001;
        #1;
        check_all("nobypass");
        chk("nobypass.i_req_r", 32'(i_req_r), 0);
        tick();
        i_rsp_v = 1'b0;
        #1;
        chk("after_rsp.i_req_r", 32'(i_req_r), 1);
        check_all("after_rsp");
        $display("after_rsp i_req_r=%b credits=%0d", i_req_r, o_credits);
        idle_inputs();
        do_reset();

        // Held slot under backpressure, then reload in the same cycle
        i_req_v = 4'b0110; o_req_r = 1'b0;
        #1; check_all("hold.first"); tick();
        for (int c = 0; c < 4; c++) begin
            #1;
            check_all("hold");
            chk("hold.id", 32'(o_req_id), 1);
            chk("hold.no_grant", 32'(i_req_r), 0);
            tick();
        end
        o_req_r = 1'b1;
        #1;
        chk("reload.i_req_r", 32'(i_req_r), 32'h4);
        check_all("reload");
        tick();
        chk("reload.id", 32'(o_req_id), 2);
        $display("hold/reload o_req_v=%0b o_req_id=%0d", o_req_v, o_req_id);
        idle_inputs();
        do_reset();

        // Drain to 5 credits, then grant and response together
        i_req_v = 4'b1111; o_req_r = 1'b1;
        for (int c = 0; c < 11; c++) begin
            #1; check_all("drain"); tick();
        end
        chk("drain.credits", 32'(o_credits), 5);
        i_rsp_v = 1'b1; i_rsp_id = 3'd1; o_rsp_r = 4'b1111;
        #1; check_all("grant_rsp"); tick();
        chk("grant_rsp.credits", 32'(o_credits), 5);
        $display("grant_rsp credits=%0d", o_credits);

        // Response backpressure on stream 2, then handshake
        i_req_v = '0; i_rsp_v = 1'b1; i_rsp_id = 3'd2; o_rsp_r = 4'b0000;
        #1;
        chk("rsp_bp.o_rsp_v", 32'(o_rsp_v), 32'h4);
        chk("rsp_bp.i_rsp_r", 32'(i_rsp_r), 0);
        check_all("rsp_bp"); tick();
        o_rsp_r = 4'b0100;
        #1;
        chk("rsp_hs.i_rsp_r", 32'(i_rsp_r), 1);
        check_all("rsp_hs"); tick();
        chk("rsp_hs.credits", 32'(o_credits), 6);
        $display("rsp_hs credits=%0d", o_credits);

        // Out-of-range response id still returns its credit
        i_rsp_id = 3'd5; o_rsp_r = 4'b0000;
        #1;
        chk("badid.o_rsp_v", 32'(o_rsp_v), 0);
        chk("badid.i_rsp_r", 32'(i_rsp_r), 1);
        check_all("badid"); tick();
        chk("badid.credits", 32'(o_credits), 7);
        $display("badid credits=%0d", o_credits);
        idle_inputs();
        do_reset();

        // Responses at full credits do not overflow
        i_rsp_v = 1'b1; i_rsp_id = 3'd0; o_rsp_r = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            #1; check_all("sat"); tick();
        end
        chk("sat.credits", 32'(o_credits), NC);
        idle_inputs();

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            i_req_v  = N'($urandom);
            o_req_r  = ($urandom_range(0, 3) != 0);
            i_rsp_v  = ($urandom_range(0, 2) == 0);
            i_rsp_id = IDW'($urandom_range(0, 7));
            o_rsp_r  = N'($urandom);
            #1;
            check_all("rand");
            tick();
            if (c % 100 == 0)
                $display("rand cycle %0d o_req_v=%0b id=%0d credits=%0d", c, o_req_v, o_req_id, o_credits);
        end
        idle_inputs();
        do_reset();

        // Asynchronous reset with requests outstanding
        i_req_v = 4'b0001; o_req_r = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1; check_all("pre_areset"); tick();
        end
        chk("pre_areset.credits", 32'(o_credits), NC - 3);
        #2;
        reset = 1'b1;
        #1;
        chk("areset.credits", 32'(o_credits), NC);
        chk("areset.o_req_v", 32'(o_req_v), 0);
        chk("areset.i_req_r", 32'(i_req_r), 0);
`ifdef L2_REQ_ARB_STATS_EN
        chk("areset.stall", o_stall_cnt, 0);
`endif
        $display("areset credits=%0d o_req_v=%0b", o_credits, o_req_v);
        idle_inputs();
        do_reset();
        #1; check_all("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
